// File: rtl/data_mem_initiator.sv
// Requester-side sequencer for the big-endian, byte-addressed 64-bit data memory.
// Loads return extended results; stores narrower than a doubleword are read-modify-write.
module data_mem_initiator #(
  parameter int MEM_BYTES = 1024,
  parameter int READ_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [63:0] ReqAddress,
  input  logic [63:0] ReqWriteData,
  output logic        RespValid,
  output logic        RespError,
  output logic [63:0] RespData,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  input  logic [63:0] MemReadData
);
  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_RESP
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [CW-1:0] wait_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_data_q;

  logic [6:0]  shift_d;
  logic [63:0] hi_mask_d;
  logic [63:0] merged_d;
  logic [63:0] load_d;
  logic        range_err_d;

  // The active field is the top 8N bits of the doubleword; shift_d brings it down to bit 0.
  always_comb begin
    shift_d     = 7'd64 - (7'd8 << size_q);
    hi_mask_d   = ~64'd0 << shift_d;
    merged_d    = (MemReadData & ~hi_mask_d) | (wdata_q << shift_d);
    load_d      = signed_q ? 64'($signed(MemReadData) >>> shift_d) : (MemReadData >> shift_d);
    range_err_d = ({1'b0, ReqAddress} + 65'd8) > 65'(MEM_BYTES);
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'd0;
      wdata_q      <= 64'd0;
      wait_q       <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && ReqValid) begin
            ready_q  <= 1'b0;
            write_q  <= ReqWrite;
            signed_q <= ReqSigned;
            size_q   <= ReqSize;
            wdata_q  <= ReqWriteData;
            if (range_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= 64'd0;
            end else if (ReqWrite && ReqSize == 2'b11) begin
              state_q     <= S_WR_ISSUE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= ReqAddress;
              mem_wdata_q <= ReqWriteData;
            end else begin
              state_q    <= S_RD_ISSUE;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= ReqAddress;
            end
          end
        end
        S_RD_ISSUE: begin
          state_q <= S_RD_WAIT;
          wait_q  <= CW'(READ_WAIT - 1);
        end
        S_RD_WAIT: begin
          if (wait_q == '0) begin
            if (write_q) begin
              state_q     <= S_WR_ISSUE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= merged_d;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= load_d;
            end
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        S_WR_ISSUE: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= 64'd0;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReqReady     = ready_q;
  assign RespValid    = resp_valid_q;
  assign RespError    = resp_err_q;
  assign RespData     = resp_data_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemoryRead   = mem_rd_q;
  assign MemoryWrite  = mem_wr_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: byte-array memory device plus a byte-level reference model.
// Directed scenarios first, then randomized requests, then a full memory image compare.
module tb_data_mem_initiator;
  localparam int MEM_BYTES = 1024;
  localparam int READ_WAIT = 1;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [63:0] ReqAddress;
  logic [63:0] ReqWriteData;
  logic        RespValid;
  logic        RespError;
  logic [63:0] RespData;
  logic [63:0] MemAddress;
  logic [63:0] MemWriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [63:0] MemReadData;

  always #5 Clock = ~Clock;

  data_mem_initiator #(.MEM_BYTES(MEM_BYTES), .READ_WAIT(READ_WAIT)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
    .RespValid(RespValid), .RespError(RespError), .RespData(RespData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  logic [7:0] dev_mem [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic       load_en;
  logic [9:0] load_addr;
  logic [7:0] load_byte;
  int         illegal_cnt = 0;
  int         overlap_cnt = 0;

  // Memory device: 8-byte transfers, byte A on bits [63:56], one cycle of read latency.
  always @(posedge Clock) begin
    if (load_en) dev_mem[load_addr] <= load_byte;
    if (MemoryRead && MemoryWrite) overlap_cnt <= overlap_cnt + 1;
    if (MemoryRead || MemoryWrite) begin
      if (MemAddress > 64'(MEM_BYTES - 8)) illegal_cnt <= illegal_cnt + 1;
      else if (MemoryRead)
        for (int i = 0; i < 8; i++) MemReadData[63-8*i -: 8] <= dev_mem[int'(MemAddress[9:0]) + i];
      else
        for (int i = 0; i < 8; i++) dev_mem[int'(MemAddress[9:0]) + i] <= MemWriteData[63-8*i -: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int a, input int n, input bit sg);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[a + i]);
    if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic model_store(input int a, input int n, input logic [63:0] wd);
    for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*(n-1-i) +: 8];
  endtask

  logic [63:0] got_data;
  logic        got_err;
  int          got_lat;
  logic [63:0] wr_data_seen;
  int          rd_k;
  int          wr_k;

  task automatic do_req(input bit wr, input bit [1:0] sz, input bit sg,
                        input logic [63:0] a, input logic [63:0] wd, input bit hold);
    logic [63:0] exp_data;
    bit          exp_err;
    int          n, exp_lat, exp_rd, rd_n, wr_n, rdy_n, waited;
    n        = 1 << sz;
    exp_err  = (a > 64'(MEM_BYTES - 8));
    exp_data = 64'd0;
    if (!exp_err && !wr) exp_data = model_load(int'(a[9:0]), n, sg);
    exp_lat  = exp_err ? 1 : (wr ? ((n == 8) ? 2 : 3 + READ_WAIT) : 2 + READ_WAIT);
    exp_rd   = (!exp_err && (!wr || n != 8)) ? 1 : 0;

    @(negedge Clock);
    waited = 0;
    while (!ReqReady && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    check("ready_before_req", 64'(ReqReady), 64'(1));
    ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddress = a; ReqWriteData = wd;
    ReqValid = 1'b1;
    @(posedge Clock);
    #1;
    if (!hold) ReqValid = 1'b0;

    got_lat = 0; got_err = 1'bx; got_data = 'x;
    rd_n = 0; wr_n = 0; rdy_n = 0; rd_k = 0; wr_k = 0; wr_data_seen = 'x;
    for (int k = 1; k <= 20 && got_lat == 0; k++) begin
      @(negedge Clock);
      if (MemoryRead) begin rd_n++; rd_k = k; end
      if (MemoryWrite) begin wr_n++; wr_k = k; wr_data_seen = MemWriteData; end
      if (ReqReady) rdy_n++;
      if (RespValid) begin
        got_lat  = k;
        got_err  = RespError;
        got_data = RespData;
        ReqValid = 1'b0;
      end
    end
    ReqValid = 1'b0;
    if (!exp_err && wr) model_store(int'(a[9:0]), n, wd);

    check("latency", 64'(got_lat), 64'(exp_lat));
    check("resp_error", 64'(got_err), 64'(exp_err));
    check("resp_data", got_data, exp_data);
    check("read_strobes", 64'(rd_n), 64'(exp_rd));
    check("write_strobes", 64'(wr_n), 64'((!exp_err && wr) ? 1 : 0));
    check("ready_while_busy", 64'(rdy_n), 64'(0));
    @(negedge Clock);
    check("resp_pulse_width", 64'(RespValid), 64'(0));
    check("resp_data_hold", RespData, got_data);
    $display("req wr=%0d sz=%0d sg=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d",
             wr, sz, sg, a, wd, got_data, got_err, got_lat);
  endtask

  logic [63:0] dw18 = 64'h0ffbea7deadbeeff;

  initial begin
    logic [7:0]  b;
    logic [63:0] a;
    int          r, seen, diffs;
    Reset_L = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAddress = 64'd0; ReqWriteData = 64'd0; load_en = 1'b0; load_addr = 10'd0; load_byte = 8'd0;

    for (int i = 0; i < MEM_BYTES; i++) begin
      b = 8'($urandom);
      if (i >= 'h18 && i < 'h20) b = dw18[63-8*(i-'h18) -: 8];
      else if (i >= 'h20 && i < 'h28) b = 8'd0;
      ref_mem[i] = b;
      @(negedge Clock);
      load_en = 1'b1; load_addr = 10'(i); load_byte = b;
    end
    @(negedge Clock);
    load_en = 1'b0;

    check("rst_ReqReady", 64'(ReqReady), 64'(0));
    check("rst_MemoryRead", 64'(MemoryRead), 64'(0));
    check("rst_MemoryWrite", 64'(MemoryWrite), 64'(0));
    check("rst_RespValid", 64'(RespValid), 64'(0));
    check("rst_RespError", 64'(RespError), 64'(0));
    check("rst_RespData", RespData, 64'd0);
    check("rst_MemAddress", MemAddress, 64'd0);
    check("rst_MemWriteData", MemWriteData, 64'd0);
    Reset_L = 1'b1;
    @(posedge Clock);
    #1;
    check("ready_after_reset", 64'(ReqReady), 64'(1));

    do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b0);
    check("t1_dword_load", got_data, 64'h0ffbea7deadbeeff);
    do_req(1'b0, 2'd0, 1'b1, 64'h19, 64'd0, 1'b0);
    check("t2_byte_signed", got_data, 64'hffff_ffff_ffff_fffb);
    do_req(1'b0, 2'd0, 1'b0, 64'h19, 64'd0, 1'b0);
    check("t2_byte_unsigned", got_data, 64'h0000_0000_0000_00fb);
    do_req(1'b0, 2'd1, 1'b1, 64'h1c, 64'd0, 1'b0);
    check("t2_half_signed", got_data, 64'hffff_ffff_ffff_eadb);

    do_req(1'b1, 2'd0, 1'b0, 64'h20, 64'hab, 1'b0);
    check("t3_merged_wdata", wr_data_seen, 64'hab00_0000_0000_0000);
    check("t3_read_to_write_gap", 64'(wr_k - rd_k), 64'(2));
    do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b0);
    check("t3_reload", got_data, 64'hab00_0000_0000_0000);

    do_req(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, 1'b0);
    check("t4_dword_wdata", wr_data_seen, 64'h1122334455667788);
    do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b0);
    check("t4_reload", got_data, 64'h1122334455667788);

    do_req(1'b0, 2'd3, 1'b0, 64'h3f9, 64'd0, 1'b0);
    check("t5_err_3f9", 64'(got_err), 64'(1));
    do_req(1'b0, 2'd3, 1'b0, 64'h3f8, 64'd0, 1'b0);
    check("t5_ok_3f8", 64'(got_err), 64'(0));
    do_req(1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
    check("t5_err_wrap", 64'(got_err), 64'(1));
    do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b1);

    // Abort a byte store during its read wait; memory at 0x20 must be untouched.
    @(negedge Clock);
    check("t6_ready", 64'(ReqReady), 64'(1));
    ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0; ReqAddress = 64'h20; ReqWriteData = 64'h5a;
    ReqValid = 1'b1;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    @(negedge Clock);
    check("t6_read_issued", 64'(MemoryRead), 64'(1));
    @(negedge Clock);
    Reset_L = 1'b0;
    #1;
    check("t6_rst_MemoryRead", 64'(MemoryRead), 64'(0));
    check("t6_rst_MemoryWrite", 64'(MemoryWrite), 64'(0));
    check("t6_rst_RespValid", 64'(RespValid), 64'(0));
    check("t6_rst_ReqReady", 64'(ReqReady), 64'(0));
    seen = 0;
    repeat (3) begin
      @(negedge Clock);
      if (RespValid || MemoryWrite || MemoryRead) seen++;
    end
    check("t6_quiet_in_reset", 64'(seen), 64'(0));
    Reset_L = 1'b1;
    @(posedge Clock);
    #1;
    check("t6_ready_after_release", 64'(ReqReady), 64'(1));
    do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b0);
    check("t6_mem_unchanged", got_data, 64'h1122334455667788);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 64'(MEM_BYTES - 16) + 64'($urandom_range(0, 15));
      else if (r == 1) a = {$urandom, $urandom};
      else             a = 64'($urandom_range(0, MEM_BYTES - 8));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom}, (t % 10) == 5);
    end

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
    check("memory_image_diffs", 64'(diffs), 64'(0));
    check("out_of_range_strobes", 64'(illegal_cnt), 64'(0));
    check("overlapping_strobes", 64'(overlap_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

- Requester-side controller for the big-endian, byte-addressed 64-bit data memory.
- Sits between the pipeline's load/store stage and the memory's `Address`/`WriteData`/`MemoryRead`/`MemoryWrite`/`ReadData` port.
- Accepts one byte, halfword, word or doubleword access at a time over a valid/ready handshake and sequences the memory strobes.
- Stores narrower than a doubleword are done as a read-modify-write; load results come back sign- or zero-extended on a one-cycle response pulse.

## Interface
Parameters:
- `MEM_BYTES`, 1024: memory size in bytes; bound for the range check.
- `READ_WAIT`, 1: cycles from the edge that samples `MemoryRead` to the edge where `MemReadData` is captured. Must be ≥1.

Ports:
- `Clock` in 1: the single clock; all state changes on its rising edge.
- `Reset_L` in 1: reset, asynchronous and active-low.
- `ReqValid` in 1: a request is present.
- `ReqReady` out 1: the unit is idle and accepts a request.
- `ReqWrite` in 1: 1 = store, 0 = load.
- `ReqSize` in 2: access size; 00 byte, 01 half, 10 word, 11 dword.
- `ReqSigned` in 1: loads only; 1 = sign-extend the result.
- `ReqAddress` in 64: byte address; any alignment is legal.
- `ReqWriteData` in 64: store value, right-aligned in the low bits.
- `RespValid` out 1: one-cycle completion pulse, for loads and stores.
- `RespError` out 1: meaningful only while `RespValid` is high; the access was out of range.
- `RespData` out 64: load result, extended to 64 bits.
- `MemAddress` out 64: drives the memory's `Address`.
- `MemWriteData` out 64: drives the memory's `WriteData`.
- `MemoryRead` out 1: memory read strobe.
- `MemoryWrite` out 1: memory write strobe.
- `MemReadData` in 64: the memory's `ReadData`.

## Operation
Memory model:
- The memory always transfers 8 bytes, from A to A+7.
- Byte A maps to bits [63:56].
- An N-byte access (N = 1, 2, 4, 8) therefore uses the top 8N bits of the doubleword at A.

Request acceptance:
- A request is accepted on a rising edge where `ReqValid` and `ReqReady` are both high.
- The fields are latched at that edge.
- `ReqValid` is ignored while `ReqReady` is low.

Range check, done at acceptance:
- Compute A + 8 in 65 bits.
- If the result is greater than `MEM_BYTES`, the request errors: go straight to RESP with `RespError`=1 and `RespData`=0.
- An errored request drives no memory strobe.

States:
- IDLE: `ReqReady`=1. On accept, the next state is:
  - RESP, if the range check errors;
  - RD_ISSUE, if the request is a load or a store with N<8;
  - WR_ISSUE, if the request is a store with N=8.
- RD_ISSUE, one cycle: `MemoryRead`=1 and `MemAddress`=A. Next state is RD_WAIT, with the wait counter loaded with `READ_WAIT`-1.
- RD_WAIT: decrement the counter each cycle. In the cycle where the counter is 0, capture `MemReadData` at the closing edge, then:
  - load: `RespData` = top 8N bits shifted down, sign-extended if `ReqSigned` else zero-extended; next state RESP;
  - store: `MemWriteData` = captured data with bits [63:64-8N] replaced by `ReqWriteData`[8N-1:0]; next state WR_ISSUE.
- WR_ISSUE, one cycle: `MemoryWrite`=1 and `MemAddress`=A. `MemWriteData` is the merged value, or for N=8 `ReqWriteData` unchanged. Next state RESP.
- RESP, one cycle: `RespValid`=1. Next state IDLE.

Output hold rules:
- `RespData` holds its last value outside RESP.
- Stores leave `RespData`=0.

## Timing
Reset:
- While `Reset_L` is low: state is IDLE.
- `ReqReady`=0, `MemoryRead`=0, `MemoryWrite`=0, `RespValid`=0, `RespError`=0.
- `RespData`, `MemAddress` and `MemWriteData` are all 0.
- `ReqReady` rises in the first cycle after `Reset_L` goes high.

Latency, counted from the accepting edge E0 to the cycle in which `RespValid` is high:
- error: cycle after E0;
- dword store: E0+2;
- load: E0+2+`READ_WAIT`;
- sub-dword store: E0+3+`READ_WAIT`.

Strobe rules:
- `MemoryRead` and `MemoryWrite` are each high for exactly one cycle per access.
- They are never high together.
- Strobes are decoded from the registered state, so they change only after edges or on reset.

Reset mid-operation:
- Asserting reset mid-operation drops all strobes immediately.
- No response is produced for the aborted request.
- A write already sampled by the memory may still commit.
- A read-modify-write aborted before WR_ISSUE leaves the memory unchanged.

Throughput:
- At most one request is outstanding.
- The next request can be accepted no earlier than the edge that closes the cycle after RESP.

Boundaries:
- A = `MEM_BYTES`-8 is legal.
- Address wrap-around is caught by the 65-bit sum; for example, 0xFFFF_FFFF_FFFF_FFFC errors.

## Test plan
Memory preload: 0x18 holds 0x0ffbea7deadbeeff; 0x20 holds 0. All scenarios use `READ_WAIT`=1.

1. Dword load at 0x18 -> `MemoryRead` pulses once; `RespData`=0x0ffbea7deadbeeff; `RespValid` at E0+3; `RespError`=0.
2. Byte and halfword loads:
   - byte 0x19, signed -> 0xffff_ffff_ffff_fffb;
   - byte 0x19, unsigned -> 0xfb;
   - half 0x1c, signed -> 0xffff_ffff_ffff_eadb.
3. Byte store of 0xab at 0x20 -> `MemoryRead`, then `MemoryWrite` two cycles later with `MemWriteData`=0xab00_0000_0000_0000; `RespValid` at E0+4. A following dword load at 0x20 returns 0xab00_0000_0000_0000.
4. Dword store of 0x1122334455667788 at 0x20 -> one `MemoryWrite` and no `MemoryRead`; `RespValid` at E0+2; a reload returns the same value.
5. Range check:
   - dword load at 0x3f9 -> `RespError`=1, `RespData`=0, no strobes, `RespValid` at E0+1;
   - load at 0x3f8 -> succeeds;
   - load at 0xFFFF_FFFF_FFFF_FFFC -> errors;
   - `ReqValid` held high while busy -> not accepted.
6. Reset asserted during RD_WAIT of a byte store -> strobes drop immediately; no `RespValid`; memory unchanged; `ReqReady`=1 in the first cycle after release.
